prog_loader: RTL and testbench

- Synthesizable program loader placed between a word-stream source (host/UART bridge) and the core's byte-addressable instruction memory.
- Holds the core in reset while it runs, serialises each incoming word little-endian into byte writes, releases the core, then counts a run budget and flags completion.
- Generalises word width, memory depth and run length.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/word_serializer.sv | 54 +++++
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOAD,
        ST_WRITE,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Number of byte lanes in one instruction word.
    function automatic int lane_count(input int xlen);
        return xlen / BYTE_W;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits one latched word into consecutive little-endian byte writes.
// Latency: first byte the cycle after load, one byte per cycle, word_done on the last lane.
// Backpressure: none; the caller must not load while a word is still in flight.
module word_serializer
    import prog_loader_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] word,
    input  logic [AW-1:0]   base_addr,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_wdata,
    output logic            word_done
);

    localparam int LANES = lane_count(XLEN);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [XLEN-1:0] shreg;
    logic [LW-1:0]   lane;

    // The low byte of the shift register is always the byte being written.
    assign mem_wdata = shreg[BYTE_W-1:0];
    assign word_done = mem_we && (lane == LW'(LANES - 1));

    // Latch a word, then walk its lanes; async reset drops mem_we at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            shreg    <= '0;
            lane     <= '0;
        end else if (load) begin
            mem_we   <= 1'b1;
            mem_addr <= base_addr;
            shreg    <= word;
            lane     <= '0;
        end else if (mem_we) begin
            if (word_done) begin
                mem_we <= 1'b0;
            end else begin
                lane     <= lane + LW'(1);
                mem_addr <= mem_addr + AW'(1);
                shreg    <= shreg >> BYTE_W;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: holds the core in reset, writes streamed words into byte memory, then runs it for a budget.
// Latency: one word per XLEN/8+1 cycles; core_rst falls the cycle after the final byte (or checksum beat).
// Backpressure: s_ready is high only in LOAD; upstream holds words while it is low.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing checksum beat after the last word.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS * XLEN / 8),
    parameter int RST_CYCLES  = 4,
    parameter int RUN_CYCLES  = 50
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [XLEN-1:0]               s_data,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [7:0]                    mem_wdata,
    output logic                          core_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [AW-$clog2(XLEN/8):0]    word_count
);

    localparam int LANES = lane_count(XLEN);
    localparam int WCW   = AW - $clog2(LANES) + 1;

    state_t        state;
    logic [31:0]   cnt;
    logic          last_q;
    logic          hs;
    logic          full;
    logic          ser_load;
    logic          word_done;
    logic          start_ok;
    logic [AW-1:0] base_addr;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [XLEN-1:0] sum;
    logic            csum_beat;
`endif

    assign hs        = (state == ST_LOAD) && s_valid && s_ready;
    assign full      = (word_count == WCW'(DEPTH_WORDS));
    assign base_addr = AW'(word_count) * AW'(LANES);

    // With an unbounded run, start is the only way out of RUN short of reset.
    assign start_ok = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR) ||
                      ((state == ST_RUN) && (RUN_CYCLES == 0));

    // Only real program words reach memory; the overflow word and checksum beat do not.
`ifdef PROG_LOADER_CHECKSUM_EN
    assign ser_load = hs && !full && !csum_beat;
`else
    assign ser_load = hs && !full;
`endif

    word_serializer #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (s_data),
        .base_addr (base_addr),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .word_done (word_done)
    );

    // Sequencer: hold, load, write, run, and the sticky done/err status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_q     <= 1'b0;
            s_ready    <= 1'b0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
            csum_beat  <= 1'b0;
`endif
        end else if (start && start_ok) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            s_ready    <= 1'b0;
            core_rst   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
            csum_beat  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    if ((cnt + 32'd1) >= 32'(RST_CYCLES)) begin
                        state   <= ST_LOAD;
                        s_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        s_ready <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (csum_beat) begin
                            if ((sum + s_data) == '0) begin
                                state    <= ST_RUN;
                                core_rst <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else
`endif
                        if (full) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state  <= ST_WRITE;
                            last_q <= s_last;
`ifdef PROG_LOADER_CHECKSUM_EN
                            sum    <= sum + s_data;
`endif
                        end
                    end
                end
                ST_WRITE: begin
                    if (word_done) begin
                        word_count <= word_count + WCW'(1);
                        if (last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum_beat <= 1'b1;
                            state     <= ST_LOAD;
                            s_ready   <= 1'b1;
`else
                            state    <= ST_RUN;
                            core_rst <= 1'b0;
                            cnt      <= '0;
`endif
                        end else begin
                            state   <= ST_LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if ((RUN_CYCLES != 0) && ((cnt + 32'd1) >= 32'(RUN_CYCLES))) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                    end else if (RUN_CYCLES != 0) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: begin
                end
                default: begin
                    state    <= ST_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                    s_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected byte writes are queued as words are offered,
// a negedge monitor pops and compares every mem_we cycle, directed checks cover control outputs.
module tb_prog_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 12;
    localparam int AW    = 6;
    localparam int RSTC  = 4;
    localparam int RUNC  = 50;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             s_valid = 1'b0;
    logic [XLEN-1:0]  s_data = '0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [7:0]       mem_wdata;
    logic             core_rst;
    logic             busy;
    logic             done;
    logic             err;
    logic [4:0]       word_count;

    always #5 clk = ~clk;

    prog_loader #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH),
        .RST_CYCLES  (RSTC),
        .RUN_CYCLES  (RUNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  img [0:63];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_cnt = 0;
    int          hs_cycle = 0;
    int          exp_wc = 0;
    logic [31:0] exp_sum = '0;

    logic [31:0] prog [0:9] = '{
        32'h00500093, 32'h00100113, 32'h002081b3, 32'h00318233, 32'h004202b3,
        32'h00528333, 32'h006303b3, 32'h00738433, 32'h008404b3, 32'hdeadbeef
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (s_ready) rdy_cnt++;

    // Monitor: every byte write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.a));
                check("wr_data", 64'(mem_wdata), 64'(e.d));
                img[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"},    64'(s_ready),    64'd0);
        check({tag, "_mem_we"},     64'(mem_we),     64'd0);
        check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
        check({tag, "_core_rst"},   64'(core_rst),   64'd1);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_err"},        64'(err),        64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_wc  = 0;
        exp_sum = '0;
    endtask

    // Offer one word; queue its expected bytes if it should reach memory.
    task automatic send_word(input logic [31:0] d, input logic l, input bit write_it, input bit keep_valid);
        bit got;
        int n;
        wr_t w;
        if (write_it) begin
            for (int k = 0; k < 4; k++) begin
                w.a = AW'(exp_wc * 4 + k);
                w.d = d[8*k +: 8];
                exp_q.push_back(w);
            end
            exp_wc++;
            exp_sum = exp_sum + d;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        got = 0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1;
                hs_cycle = cyc;
            end
            n++;
        end
        if (!got) begin
            check("handshake_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep_valid) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
        end
    endtask

    // Send the trailing checksum beat when the loader expects one.
    task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(~exp_sum + 32'd1, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        int h0;
        int h1;
        int pulses;

        // Reset values
        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic load of 10 words, with an ignored start mid-load
        pulse_start();
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_core_rst", 64'(core_rst), 64'd1);
        check("hold_s_ready", 64'(s_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            send_word(prog[i], (i == 9), 1'b1, 1'b0);
            if (i == 4) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        finish_load();
        @(negedge clk);
        check("run_core_rst_low", 64'(core_rst), 64'd0);
`else
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("last_byte_core_rst", 64'(core_rst), 64'd1);
        check("last_byte_mem_we", 64'(mem_we), 64'd1);
        @(negedge clk);
        check("run_core_rst_low", 64'(core_rst), 64'd0);
`endif
        check("basic_word_count", 64'(word_count), 64'd10);
        check("img_addr0", 64'(img[0]), 64'h93);
        check("img_addr3", 64'(img[3]), 64'h00);
        check("img_addr39", 64'(img[39]), 64'hde);

        // Run budget: core_rst low for exactly RUNC cycles
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (core_rst) break;
            n++;
        end
        check("run_low_cycles", 64'(n), 64'(RUNC));
        check("run_done", 64'(done), 64'd1);
        check("run_core_rst_back", 64'(core_rst), 64'd1);
        check("run_busy", 64'(busy), 64'd0);

        // Backpressure: s_valid held high across three words
        @(posedge clk);
        #1;
        pulse_start();
        check("restart_done_clear", 64'(done), 64'd0);
        rdy_cnt = 0;
        send_word(32'h11223344, 1'b0, 1'b1, 1'b1);
        h0 = hs_cycle;
        send_word(32'h55667788, 1'b0, 1'b1, 1'b1);
        h1 = hs_cycle;
        send_word(32'h99aabbcc, 1'b1, 1'b1, 1'b0);
        pulses = rdy_cnt;
        check("bp_spacing_1", 64'(h1 - h0), 64'd5);
        check("bp_spacing_2", 64'(hs_cycle - h1), 64'd5);
        check("bp_ready_pulses", 64'(pulses), 64'd3);
        finish_load();
        wait_done("bp_done");
        check("bp_word_count", 64'(word_count), 64'd3);

        // Overflow: DEPTH words without last, then one more
        @(posedge clk);
        #1;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'h10000000 + 32'(i * 32'h01010101), 1'b0, 1'b1, 1'b0);
        end
        send_word(32'hbadbad00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_core_rst", 64'(core_rst), 64'd1);
        check("ovf_busy", 64'(busy), 64'd0);
        check("ovf_s_ready", 64'(s_ready), 64'd0);
        check("ovf_word_count", 64'(word_count), 64'(DEPTH));
        repeat (3) @(negedge clk);
        check("ovf_all_written", 64'(exp_q.size()), 64'd0);

        // Reset during the second byte of word 3, then reload from address 0
        @(posedge clk);
        #1;
        pulse_start();
        check("restart_err_clear", 64'(err), 64'd0);
        send_word(32'h01020304, 1'b0, 1'b1, 1'b0);
        send_word(32'h05060708, 1'b0, 1'b1, 1'b0);
        send_word(32'h090a0b0c, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_pending_bytes", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'hcafef00d, 1'b1, 1'b1, 1'b0);
        finish_load();
        wait_done("reload_done");
        check("reload_word_count", 64'(word_count), 64'd1);
        check("reload_img0", 64'(img[0]), 64'h0d);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum beat: good sum runs, bad sum errors
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'd1, 1'b0, 1'b1, 1'b0);
        send_word(32'd2, 1'b0, 1'b1, 1'b0);
        send_word(32'd3, 1'b1, 1'b1, 1'b0);
        send_word(32'hfffffffa, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("csum_good_run", 64'(core_rst), 64'd0);
        check("csum_good_err", 64'(err), 64'd0);
        check("csum_word_count", 64'(word_count), 64'd3);
        wait_done("csum_good_done");
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'd1, 1'b0, 1'b1, 1'b0);
        send_word(32'd2, 1'b0, 1'b1, 1'b0);
        send_word(32'd3, 1'b1, 1'b1, 1'b0);
        send_word(32'hfffffffb, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("csum_bad_err", 64'(err), 64'd1);
        check("csum_bad_core_rst", 64'(core_rst), 64'd1);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
